// File: rtl/sccpu_dbg_pkg.sv
// Shared types and constants for the sccomp register-file dump engine.
// The FSM states, header magic, cause codes and snapshot geometry live here.
package sccpu_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_PCW   = 3'd2,
    ST_INW   = 3'd3,
    ST_FETCH = 3'd4,
    ST_SEND  = 3'd5,
    ST_DONE  = 3'd6
  } dump_state_e;

  localparam logic [15:0] HDR_MAGIC = 16'hD0D0;

  localparam logic [1:0] CAUSE_BP = 2'b01;
  localparam logic [1:0] CAUSE_WD = 2'b10;

  localparam int DUMP_WORDS  = 35;
  localparam int FIXED_WORDS = 3;
  localparam int RF_SEL_W    = 5;

  // Index of the final register word: 35 words minus header/pc/instr, zero-based.
  localparam logic [RF_SEL_W-1:0] LAST_SEL = RF_SEL_W'(DUMP_WORDS - FIXED_WORDS - 1);

  function automatic logic [31:0] make_header(input logic [1:0] cause);
    return {HDR_MAGIC, 14'b0, cause};
  endfunction

endpackage

// File: rtl/rf_dump_engine_if.sv
// Word-stream handshake carrying the 35-word snapshot out of the dump engine.
// The engine is the master; whoever drains the snapshot is the slave.
interface rf_dump_engine_if;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/rf_dump_engine.sv
// Debug initiator for sccomp: on breakpoint or watchdog it halts the CPU and
// streams header, PC, instruction and rf[0..31] over a valid/ready word port.
module rf_dump_engine
  import sccpu_dbg_pkg::*;
#(
  parameter int MAX_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [31:0]         pc,
  input  logic [31:0]         instr,
  input  logic                bp_en,
  input  logic [31:0]         bp_addr,
  input  logic                resume,
  output logic [RF_SEL_W-1:0] reg_sel,
  input  logic [31:0]         reg_data,
  output logic                cpu_halt,
  output logic                dump_done,
  rf_dump_engine_if.master    out_if
);

  localparam logic [15:0] WD_LIMIT = 16'(MAX_CYCLES);

  dump_state_e         state_q, state_d;
  logic [15:0]         cyc_q, cyc_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         in_q, in_d;
  logic [1:0]          cause_q, cause_d;
  logic [RF_SEL_W-1:0] sel_q, sel_d;
  logic [31:0]         rdata_q, rdata_d;

  logic        bp_hit;
  logic        wd_hit;
  logic        trigger;
  logic        word_acc;
  logic        valid;
  logic [31:0] data;
  logic        last;

  // Hits are only meaningful while idle; during a dump bp_en/bp_addr are ignored.
  always_comb begin
    bp_hit   = bp_en && (pc == bp_addr);
    wd_hit   = (cyc_q == WD_LIMIT);
    trigger  = (state_q == ST_IDLE) && (bp_hit || wd_hit);
    word_acc = valid && out_if.out_ready;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (trigger) state_d = ST_HDR;
      ST_HDR:   if (word_acc) state_d = ST_PCW;
      ST_PCW:   if (word_acc) state_d = ST_INW;
      ST_INW:   if (word_acc) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_SEND;
      ST_SEND: begin
        if (word_acc) state_d = (sel_q == LAST_SEL) ? ST_DONE : ST_FETCH;
      end
      ST_DONE:  if (resume) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cyc_d   = cyc_q;
    pc_d    = pc_q;
    in_d    = in_q;
    cause_d = cause_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;

    if (state_q == ST_IDLE && cyc_q != WD_LIMIT) begin
      cyc_d = cyc_q + 16'd1;
    end

    if (trigger) begin
      pc_d    = pc;
      in_d    = instr;
      cause_d = (wd_hit ? CAUSE_WD : 2'b00) | (bp_hit ? CAUSE_BP : 2'b00);
    end

    // rf[0] is architecturally zero, so never trust the read port for it.
    if (state_q == ST_FETCH) begin
      rdata_d = (sel_q == '0) ? 32'd0 : reg_data;
    end

    if (state_q == ST_SEND && word_acc) begin
      sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + RF_SEL_W'(1);
    end

    if (state_q == ST_DONE && resume) begin
      cyc_d   = 16'd0;
      cause_d = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_q   <= 16'd0;
      pc_q    <= 32'd0;
      in_q    <= 32'd0;
      cause_q <= 2'b00;
      sel_q   <= '0;
      rdata_q <= 32'd0;
    end else begin
      cyc_q   <= cyc_d;
      pc_q    <= pc_d;
      in_q    <= in_d;
      cause_q <= cause_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode only registered state, so they hold steady under backpressure.
  always_comb begin
    valid = 1'b0;
    data  = 32'd0;
    last  = 1'b0;
    unique case (state_q)
      ST_HDR: begin
        valid = 1'b1;
        data  = make_header(cause_q);
      end
      ST_PCW: begin
        valid = 1'b1;
        data  = pc_q;
      end
      ST_INW: begin
        valid = 1'b1;
        data  = in_q;
      end
      ST_SEND: begin
        valid = 1'b1;
        data  = rdata_q;
        last  = (sel_q == LAST_SEL);
      end
      default: begin
        valid = 1'b0;
        data  = 32'd0;
        last  = 1'b0;
      end
    endcase
    cpu_halt  = (state_q != ST_IDLE) || trigger;
    dump_done = (state_q == ST_DONE);
  end

  assign reg_sel          = sel_q;
  assign out_if.out_valid = valid;
  assign out_if.out_data  = data;
  assign out_if.out_last  = last;

endmodule

// File: doc/rf_dump_engine.md
# rf_dump_engine

Hardware debug initiator for the single-cycle MIPS computer (`sccomp`). It watches the CPU's PC and a free-running cycle counter. On a breakpoint match or watchdog expiry it freezes the CPU and walks the `reg_sel`/`reg_data` register-read port. It streams a 35-word snapshot (header, PC, instruction, rf[0..31]) out over a valid/ready word interface, so the team gets the testbench's register dump on silicon. The block sits beside `sccomp`: it drives `reg_sel`, reads `reg_data`, and gates the CPU clock enable via `cpu_halt`.

## Interface
- `MAX_CYCLES`, default 1000: watchdog trigger count in unhalted cycles; must be ≥1 and < 2^16.
- `clk` in 1: single clock, all state on rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `pc` in 32: current CPU PC.
- `instr` in 32: current CPU instruction.
- `bp_en` in 1: breakpoint enable.
- `bp_addr` in 32: breakpoint PC.
- `resume` in 1: single-cycle pulse; releases the CPU after a dump.
- `reg_sel` out 5: register-file read select into `sccomp`.
- `reg_data` in 32: combinational register-file read data for `reg_sel`.
- `cpu_halt` out 1: CPU clock-enable inhibit.
- `out_valid` out 1, `out_ready` in 1: dump stream handshake.
- `out_data` out 32: dump word.
- `out_last` out 1: marks word 34.
- `dump_done` out 1: high in the DONE state.

## Operation
- **States:** IDLE, HDR, PCW, INW, FETCH, SEND, DONE.
- **IDLE:**
  - `cyc` (16 b) increments each cycle and saturates at MAX_CYCLES.
  - Trigger condition: `bp_hit = bp_en && pc==bp_addr`; `wd_hit = cyc==MAX_CYCLES`.
  - On trigger, capture `pc`→`pc_q`, `instr`→`in_q`, and `cause={wd_hit,bp_hit}`. Both hits together give cause 2'b11.
  - Then go to HDR.
- **Word sequence:**
  - HDR: word 0 = {16'hD0D0, 14'b0, cause}.
  - PCW: word 1 = `pc_q`.
  - INW: word 2 = `in_q`.
  - Then for i=0..31: FETCH drives `reg_sel=i` with `out_valid=0` for one cycle. SEND then holds `out_data` = registered `reg_data` and `out_valid=1`. For i=0 the word is forced to 0.
  - Words 3..34 are rf[0..31].
- **Advance rule:** a word advances only on a cycle where `out_valid && out_ready`. After word 34 the block enters DONE.
- **DONE:** `cpu_halt=1`, `dump_done=1`, `out_valid=0`. `resume` moves to IDLE, clears `cyc` to 0 and clears `cause`.
- `resume` in any state other than DONE is ignored.
- **cpu_halt** = (state≠IDLE) | (state==IDLE && trigger). The breakpoint instruction is therefore not executed; the snapshot is the pre-execution state.
- `bp_addr` or `bp_en` changes mid-dump have no effect.
- After resume with the PC still equal to `bp_addr`, the block retriggers immediately. Software must move `bp_addr` or clear `bp_en` first.

## Timing
- **Reset values:**
  - state=IDLE, `cyc`=0, `reg_sel`=0, `cpu_halt`=0 (trigger also false).
  - `out_valid`=0, `out_data`=0, `out_last`=0, `dump_done`=0.
- **Trigger latency:** trigger seen at edge N; header is valid after edge N (1 cycle).
- **Throughput with `out_ready` held high:**
  - Header, PC and instr words: 1 cycle each.
  - Each rf word: 2 cycles (FETCH+SEND).
  - Total 3+64 = 67 cycles from HDR entry to DONE.
- **Stall behaviour:** `out_data` and `out_last` stay stable while `out_valid && !out_ready`. `reg_sel` stays stable through SEND.
- **Reset mid-dump:** asserting `rstn` low aborts immediately to reset values; no partial word is re-sent.

## Structure
- Package `sccpu_dbg_pkg` holds:
  - state enum;
  - header magic 16'hD0D0;
  - cause codes (BP=2'b01, WD=2'b10);
  - DUMP_WORDS=35;
  - RF_SEL_W=5.
- Single module with no sub-module; the counter, capture registers and FSM are all local.

## Test plan
- **Breakpoint, no backpressure:** `bp_en=1`, `bp_addr=0x48`, `pc` reaches 0x48 with `instr`=0x08000012.
  - Words: 0xD0D00001, 0x00000048, 0x08000012, 0, rf1..rf31.
  - `out_last` on word 34; DONE 67 cycles after the header.
- **Watchdog:** `bp_en=0`, MAX_CYCLES=10 → trigger on the 11th IDLE cycle, header 0xD0D00002.
- **Simultaneous hits:** `pc==bp_addr` on the same cycle that `cyc` reaches MAX_CYCLES → header 0xD0D00003.
- **Backpressure:** drop `out_ready` for 5 cycles during word 7 (rf4) → `out_data` and `reg_sel=4` stay constant, with no duplicate or skipped words.
- **Resume:** pulse `resume` in DONE → `cpu_halt` falls next cycle and `cyc` restarts from 0. A `resume` pulse during SEND is ignored.
- **Reset mid-dump:** assert `rstn` low at word 20 → all outputs return to reset values asynchronously; after release the block stays in IDLE until the next trigger.
